dma_ctrl_regs: RTL and testbench

AXI4-Lite responder (slave) register block giving a bus master control over the DMA engine: run/stop, soft reset, source address, transfer length, status readback and completion interrupt. It sits between the system AXI-Lite interconnect and the `Dma_Ctrl` datapath. It converts register writes into a one-cycle `dma_start` pulse and the engine's `dma_done` pulse into status bits and `irq`.

---
 rtl/dma_ctrl_regs_if.sv | 33 +++
 rtl/dma_ctrl_regs.sv | 208 ++++++++++++++++++++
 tb/tb_dma_ctrl_regs.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_regs_if.sv
// AXI4-Lite register-port bundle for the DMA control block.
// The master drives addresses, data and the valid/ready signals it owns; the slave answers.
interface dma_ctrl_regs_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/dma_ctrl_regs.sv
// AXI4-Lite register block for the DMA engine: CR/SR/SA/LENGTH, start and
// soft-reset pulses, completion status and a registered interrupt.
module dma_ctrl_regs #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 26
) (
    input  logic             clk,
    input  logic             rst,
    dma_ctrl_regs_if.slave   s_axi_lite,
    output logic [31:0]      dma_src_addr,
    output logic [LEN_W-1:0] dma_length,
    output logic             dma_start,
    output logic             dma_soft_rst,
    input  logic             dma_done,
    output logic             irq,
    output logic [1:0]       dbg_wr_state
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] IDX_CR  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SR  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_SA  = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_LEN = IDX_W'(10);

    // Handshake rule on every channel: a beat transfers on a rising edge where
    // valid and ready are both 1; valid, once raised, holds until that edge.
    typedef enum logic [1:0] {
        WR_COLLECT = 2'd0,
        WR_EXEC    = 2'd1,
        WR_RESP    = 2'd2
    } wr_state_t;

    wr_state_t wr_state, wr_state_next;

    logic             live;
    logic             aw_full, w_full;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [1:0]       bresp_q;

    logic             rs, irq_en, idle, ioc;

    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_data;
    logic             rd_err;

    logic             exec;
    logic             is_cr, is_sr, is_sa, is_len;
    logic [31:0]      strb_mask;
    logic [31:0]      sa_merged, len_merged;
    logic [LEN_W-1:0] len_new;
    logic             len_ok, soft_req, wr_err;

    assign s_axi_lite.awready = live && (wr_state == WR_COLLECT) && !aw_full;
    assign s_axi_lite.wready  = live && (wr_state == WR_COLLECT) && !w_full;
    assign s_axi_lite.bvalid  = (wr_state == WR_RESP);
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.arready = live && !rvalid_q;
    assign s_axi_lite.rvalid  = rvalid_q;
    assign s_axi_lite.rdata   = rdata_q;
    assign s_axi_lite.rresp   = rresp_q;

    assign aw_hs = s_axi_lite.awvalid && s_axi_lite.awready;
    assign w_hs  = s_axi_lite.wvalid && s_axi_lite.wready;
    assign b_hs  = s_axi_lite.bvalid && s_axi_lite.bready;
    assign ar_hs = s_axi_lite.arvalid && s_axi_lite.arready;
    assign r_hs  = rvalid_q && s_axi_lite.rready;

    assign dbg_wr_state = wr_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= WR_COLLECT;
            live     <= 1'b0;
        end else begin
            wr_state <= wr_state_next;
            live     <= 1'b1;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            WR_COLLECT: if ((aw_full || aw_hs) && (w_full || w_hs)) wr_state_next = WR_EXEC;
            WR_EXEC:    wr_state_next = WR_RESP;
            WR_RESP:    if (b_hs) wr_state_next = WR_COLLECT;
            default:    wr_state_next = WR_COLLECT;
        endcase
    end

    // AW and W beats are held independently until both are present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= s_axi_lite.awaddr[ADDR_W-1:2];
            end else if (wr_state == WR_EXEC) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi_lite.wdata;
                w_strb_q <= s_axi_lite.wstrb;
            end else if (wr_state == WR_EXEC) begin
                w_full <= 1'b0;
            end
        end
    end

    assign exec      = (wr_state == WR_EXEC);
    assign is_cr     = (aw_idx_q == IDX_CR);
    assign is_sr     = (aw_idx_q == IDX_SR);
    assign is_sa     = (aw_idx_q == IDX_SA);
    assign is_len    = (aw_idx_q == IDX_LEN);
    assign strb_mask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
    assign sa_merged  = (dma_src_addr & ~strb_mask) | (w_data_q & strb_mask);
    assign len_merged = (32'(dma_length) & ~strb_mask) | (w_data_q & strb_mask);
    assign len_new    = len_merged[LEN_W-1:0];
    assign len_ok     = rs && idle && (len_new != '0);
    assign soft_req   = is_cr && w_strb_q[0] && w_data_q[2];
    assign wr_err     = !(is_cr || is_sr || is_sa || (is_len && len_ok));

    // Completion is applied after the bus write so a same-cycle IOC clear loses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs           <= 1'b0;
            irq_en       <= 1'b0;
            idle         <= 1'b1;
            ioc          <= 1'b0;
            dma_src_addr <= '0;
            dma_length   <= '0;
            dma_start    <= 1'b0;
            dma_soft_rst <= 1'b0;
            irq          <= 1'b0;
            bresp_q      <= 2'b00;
        end else begin
            dma_start    <= 1'b0;
            dma_soft_rst <= 1'b0;
            irq          <= ioc & irq_en;
            if (exec) begin
                bresp_q <= wr_err ? 2'b10 : 2'b00;
                if (is_cr) begin
                    if (soft_req) begin
                        rs           <= 1'b0;
                        idle         <= 1'b1;
                        ioc          <= 1'b0;
                        dma_soft_rst <= 1'b1;
                    end else begin
                        if (w_strb_q[0]) rs <= w_data_q[0];
                        if (w_strb_q[1]) irq_en <= w_data_q[12];
                    end
                end
                if (is_sr && w_strb_q[1] && w_data_q[12]) ioc <= 1'b0;
                if (is_sa) dma_src_addr <= sa_merged;
                if (is_len && len_ok) begin
                    dma_length <= len_new;
                    idle       <= 1'b0;
                    dma_start  <= 1'b1;
                end
            end
            if (dma_done && !idle) begin
                idle <= 1'b1;
                ioc  <= 1'b1;
            end
        end
    end

    assign ar_idx = s_axi_lite.araddr[ADDR_W-1:2];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ar_idx)
            IDX_CR:  rd_data = {19'd0, irq_en, 11'd0, rs};
            IDX_SR:  rd_data = {19'd0, ioc, 10'd0, idle, ~rs};
            IDX_SA:  rd_data = dma_src_addr;
            IDX_LEN: rd_data = 32'(dma_length);
            default: rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi_lite.awaddr[1:0], s_axi_lite.araddr[1:0], len_merged[31:LEN_W]};
endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Bench for dma_ctrl_regs: directed register scenarios plus randomized traffic,
// checked every cycle against a transaction-level register model.
module tb_dma_ctrl_regs;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 26;
    localparam logic [31:0] LEN_MASK = 32'h03FF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dma_ctrl_regs_if #(.ADDR_W(ADDR_W)) bus ();

    logic [31:0]      dma_src_addr;
    logic [LEN_W-1:0] dma_length;
    logic             dma_start;
    logic             dma_soft_rst;
    logic             dma_done = 1'b0;
    logic             irq;
    logic [1:0]       wr_state_unused;

    dma_ctrl_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_lite   (bus.slave),
        .dma_src_addr (dma_src_addr),
        .dma_length   (dma_length),
        .dma_start    (dma_start),
        .dma_soft_rst (dma_soft_rst),
        .dma_done     (dma_done),
        .irq          (irq),
        .dbg_wr_state (wr_state_unused)
    );

    int checks = 0;
    int errors = 0;

    // register model
    logic              m_live = 1'b0;
    logic              m_rs = 1'b0, m_en = 1'b0, m_idle = 1'b1, m_ioc = 1'b0;
    logic [31:0]       m_sa = '0, m_len = '0;
    logic              exp_rvalid = 1'b0, exp_bvalid = 1'b0, exp_irq = 1'b0;
    logic [1:0]        exp_bresp = 2'b00;
    logic [33:0]       exp_q[$];
    logic              aw_pend = 1'b0, w_pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [31:0]       pend_data = '0;
    logic [3:0]        pend_strb = '0;
    int                cyc = 0, start_cyc = -1, soft_cyc = -1;
    logic              aw_rdy_pre, w_rdy_pre, ar_rdy_pre, idle_pre;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [33:0] model_read(input logic [ADDR_W-1:0] a);
        case (a[9:2])
            8'h00:   return {2'b00, (m_en ? 32'h1000 : 32'h0) | (m_rs ? 32'h1 : 32'h0)};
            8'h01:   return {2'b00, (m_ioc ? 32'h1000 : 32'h0) | (m_idle ? 32'h2 : 32'h0) | (m_rs ? 32'h0 : 32'h1)};
            8'h06:   return {2'b00, m_sa};
            8'h0A:   return {2'b00, m_len};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] nv;
        exp_bresp = 2'b00;
        case (a[9:2])
            8'h00: begin
                if (s[0] && d[2]) begin
                    m_rs = 1'b0; m_idle = 1'b1; m_ioc = 1'b0; soft_cyc = cyc;
                end else begin
                    if (s[0]) m_rs = d[0];
                    if (s[1]) m_en = d[12];
                end
            end
            8'h01: if (s[1] && d[12]) m_ioc = 1'b0;
            8'h06: m_sa = merge(m_sa, d, s);
            8'h0A: begin
                nv = merge(m_len, d, s) & LEN_MASK;
                if (m_rs && m_idle && nv != 0) begin
                    m_len = nv; m_idle = 1'b0; start_cyc = cyc;
                end else begin
                    exp_bresp = 2'b10;
                end
            end
            default: exp_bresp = 2'b10;
        endcase
    endtask

    // model advance: all bus/input values read here are the pre-edge ones
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_live = 1'b0; m_rs = 1'b0; m_en = 1'b0; m_idle = 1'b1; m_ioc = 1'b0;
            m_sa = '0; m_len = '0; exp_rvalid = 1'b0; exp_bvalid = 1'b0; exp_irq = 1'b0;
            exp_bresp = 2'b00; aw_pend = 1'b0; w_pend = 1'b0; exp_q.delete();
            start_cyc = -1; soft_cyc = -1;
        end else begin
            aw_rdy_pre = m_live && !aw_pend && !exp_bvalid;
            w_rdy_pre  = m_live && !w_pend && !exp_bvalid;
            ar_rdy_pre = m_live && !exp_rvalid;
            idle_pre   = m_idle;
            exp_irq    = m_ioc & m_en;
            if (ar_rdy_pre && bus.arvalid) begin
                exp_q.push_back(model_read(bus.araddr));
                exp_rvalid = 1'b1;
            end else if (exp_rvalid && bus.rready) begin
                void'(exp_q.pop_front());
                exp_rvalid = 1'b0;
            end
            if (exp_bvalid && bus.bready) exp_bvalid = 1'b0;
            if (aw_pend && w_pend) begin
                model_write(pend_addr, pend_data, pend_strb);
                exp_bvalid = 1'b1;
                aw_pend = 1'b0;
                w_pend = 1'b0;
            end
            if (aw_rdy_pre && bus.awvalid) begin
                aw_pend = 1'b1; pend_addr = bus.awaddr;
            end
            if (w_rdy_pre && bus.wvalid) begin
                w_pend = 1'b1; pend_data = bus.wdata; pend_strb = bus.wstrb;
            end
            if (dma_done && !idle_pre) begin
                m_idle = 1'b1; m_ioc = 1'b1;
            end
            m_live = 1'b1;
        end
    end

    // per-cycle compare, mid-cycle
    always @(negedge clk) begin
        check("awready", 34'(bus.awready), 34'(m_live && !aw_pend && !exp_bvalid));
        check("wready", 34'(bus.wready), 34'(m_live && !w_pend && !exp_bvalid));
        check("bvalid", 34'(bus.bvalid), 34'(exp_bvalid));
        check("arready", 34'(bus.arready), 34'(m_live && !exp_rvalid));
        check("rvalid", 34'(bus.rvalid), 34'(exp_rvalid));
        if (exp_bvalid || !rst) check("bresp", 34'(bus.bresp), 34'(exp_bresp));
        if (exp_rvalid) begin
            if (exp_q.size() == 0) check("rdata_queue", 34'(1), 34'(0));
            else check("rdata", {bus.rresp, bus.rdata}, exp_q[0]);
        end else if (!rst) begin
            check("rdata_reset", {bus.rresp, bus.rdata}, 34'(0));
        end
        check("src_addr", 34'(dma_src_addr), 34'(m_sa));
        check("length", 34'(dma_length), 34'(m_len));
        check("dma_start", 34'(dma_start), 34'(cyc == start_cyc));
        check("dma_soft_rst", 34'(dma_soft_rst), 34'(cyc == soft_cyc));
        check("irq", 34'(irq), 34'(exp_irq));
    end

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=no_handshake required=handshake", name);
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int n;
        fork
            begin
                int k = 0;
                if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
                bus.awaddr = a; bus.awvalid = 1'b1;
                @(posedge clk);
                while (!bus.awready && k < 100) begin @(posedge clk); k++; end
                if (k >= 100) timeout("aw");
                #1 bus.awvalid = 1'b0;
            end
            begin
                int k = 0;
                if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
                bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
                @(posedge clk);
                while (!bus.wready && k < 100) begin @(posedge clk); k++; end
                if (k >= 100) timeout("w");
                #1 bus.wvalid = 1'b0;
            end
        join
        if (b_dly > 0) begin repeat (b_dly) @(posedge clk); #1; end
        bus.bready = 1'b1;
        n = 0;
        @(posedge clk);
        while (!bus.bvalid && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) timeout("b");
        resp = bus.bresp;
        #1 bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1'b1;
        @(posedge clk);
        while (!bus.arready && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) timeout("ar");
        #1 bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        @(posedge clk);
        while (!bus.rvalid && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) timeout("r");
        d = bus.rdata; resp = bus.rresp;
        #1 bus.rready = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [1:0] req, input string name);
        logic [1:0] r;
        axi_write(a, d, 4'hF, 0, 0, 0, r);
        check(name, 34'(r), 34'(req));
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] req_d, input logic [1:0] req_r, input string name);
        logic [31:0] d;
        logic [1:0] r;
        axi_read(a, d, r);
        check(name, {r, d}, {req_r, req_d});
    endtask

    task automatic pulse_done();
        dma_done = 1'b1;
        @(posedge clk);
        #1 dma_done = 1'b0;
    endtask

    logic rand_stop = 1'b0;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        rd(10'h004, 32'h0000_0003, 2'b00, "sr_after_reset");
        wr(10'h000, 32'h0000_1001, 2'b00, "cr_write");
        wr(10'h018, 32'h1000_0000, 2'b00, "sa_write");
        wr(10'h028, 32'h0000_0100, 2'b00, "len_accept");
        check("len_out", 34'(dma_length), 34'(32'h100));
        rd(10'h004, 32'h0000_0000, 2'b00, "sr_busy");
        pulse_done();
        rd(10'h004, 32'h0000_1002, 2'b00, "sr_done");
        check("irq_set", 34'(irq), 34'(1));
        wr(10'h004, 32'h0000_1000, 2'b00, "sr_w1c");
        rd(10'h004, 32'h0000_0002, 2'b00, "sr_cleared");
        check("irq_clear", 34'(irq), 34'(0));

        wr(10'h028, 32'h0000_0080, 2'b00, "len_accept2");
        wr(10'h028, 32'h0000_0040, 2'b10, "len_busy");
        rd(10'h028, 32'h0000_0080, 2'b00, "len_kept_busy");
        rd(10'h3FC, 32'h0000_0000, 2'b10, "rd_unmapped");
        wr(10'h3FC, 32'h1234_5678, 2'b10, "wr_unmapped");

        wr(10'h000, 32'h0000_0001, 2'b00, "cr_no_irq");
        wr(10'h000, 32'h0000_0004, 2'b00, "cr_soft_rst");
        rd(10'h004, 32'h0000_0003, 2'b00, "sr_after_soft");
        rd(10'h000, 32'h0000_0000, 2'b00, "cr_after_soft");
        wr(10'h028, 32'h0000_0040, 2'b10, "len_rs0");
        wr(10'h000, 32'h0000_0001, 2'b00, "cr_run");
        wr(10'h028, 32'h0000_0000, 2'b10, "len_zero");
        rd(10'h028, 32'h0000_0080, 2'b00, "len_kept");

        begin
            logic [1:0] r;
            axi_write(10'h018, 32'hA5A5_0F0F, 4'hF, 3, 0, 5, r);
            check("w_first_resp", 34'(r), 34'(0));
            rd(10'h018, 32'hA5A5_0F0F, 2'b00, "sa_w_first");
        end

        wr(10'h000, 32'h0000_1001, 2'b00, "cr_run_irq");
        wr(10'h028, 32'h0000_0010, 2'b00, "len_accept3");
        begin
            logic [1:0] r;
            fork
                axi_write(10'h004, 32'h0000_1000, 4'hF, 0, 0, 0, r);
                begin
                    @(posedge clk);
                    #1 dma_done = 1'b1;
                    @(posedge clk);
                    #1 dma_done = 1'b0;
                end
            join
        end
        rd(10'h004, 32'h0000_1002, 2'b00, "ioc_set_wins");

        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    logic [ADDR_W-1:0] a, a2;
                    logic [31:0] d, rdv;
                    logic [3:0] s;
                    logic [1:0] r, r2;
                    logic [7:0] idx;
                    int op;
                    case ($urandom_range(0, 4))
                        0: idx = 8'h00;
                        1: idx = 8'h01;
                        2: idx = 8'h06;
                        3: idx = 8'h0A;
                        default: idx = 8'($urandom);
                    endcase
                    a = {idx, 2'($urandom)};
                    case (idx)
                        8'h00: d = ($urandom_range(0, 3) != 0 ? 32'h1 : 32'h0) |
                                   ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0) |
                                   ($urandom_range(0, 9) == 0 ? 32'h4 : 32'h0);
                        8'h01: d = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h0;
                        8'h0A: d = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 4096));
                        default: d = $urandom;
                    endcase
                    s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                    a2 = {8'($urandom_range(0, 1) != 0 ? 8'h01 : 8'($urandom)), 2'b00};
                    op = $urandom_range(0, 9);
                    if (op < 5) begin
                        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
                    end else if (op < 8) begin
                        axi_read(a, rdv, r);
                    end else begin
                        fork
                            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
                            axi_read(a2, rdv, r2);
                        join
                    end
                end
                rand_stop = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    dma_done = ($urandom_range(0, 5) == 0);
                    @(posedge clk);
                    #1;
                end
                dma_done = 1'b0;
            end
        join

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        checks++;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
